// File: rtl/serial_cmp_ctrl_if.sv
// rtl/serial_cmp_ctrl_if.sv - operand/result handshake and shared equality-cell bus for serial_cmp_ctrl
interface serial_cmp_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         done_tick;
    logic         eq;
    logic         gt;
    logic         lt;
    logic         cell_a;
    logic         cell_b;
    logic         cell_eq;

    // Sequencer side: takes operands and the cell result, drives results and cell inputs
    modport slave (
        input  start,
        input  a,
        input  b,
        input  cell_eq,
        output ready,
        output done_tick,
        output eq,
        output gt,
        output lt,
        output cell_a,
        output cell_b
    );

    // Environment side: operand producer plus the shared 1-bit equality cell
    modport master (
        output start,
        output a,
        output b,
        output cell_eq,
        input  ready,
        input  done_tick,
        input  eq,
        input  gt,
        input  lt,
        input  cell_a,
        input  cell_b
    );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - MSB-first bit-serial unsigned comparator sequencer over a shared equality cell
module serial_cmp_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_cmp_ctrl_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] a_reg_q, a_reg_d;
    logic [N-1:0] b_reg_q, b_reg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         eq_q, eq_d;
    logic         gt_q, gt_d;
    logic         lt_q, lt_d;
    logic         cell_a;
    logic         cell_b;

    // The cell only sees live bits while comparing; zeros otherwise
    assign cell_a = (state_q == CMP) ? a_reg_q[N-1] : 1'b0;
    assign cell_b = (state_q == CMP) ? b_reg_q[N-1] : 1'b0;

    assign bus.cell_a    = cell_a;
    assign bus.cell_b    = cell_b;
    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;

    // Next-state and datapath update; cell_eq is only looked at inside CMP
    always_comb begin
        state_d = state_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_reg_d = bus.a;
                    b_reg_d = bus.b;
                    cnt_d   = CNT_LAST;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!bus.cell_eq) begin
                    // First differing bit from the MSB decides the order
                    gt_d    = cell_a;
                    lt_d    = ~cell_a;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    a_reg_d = {a_reg_q[N-2:0], 1'b0};
                    b_reg_d = {b_reg_q[N-2:0], 1'b0};
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight comparison
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_reg_q <= '0;
            b_reg_q <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end
endmodule
